// File: rtl/sync_mode_detect.sv
// sync_mode_detect: front-end sync qualifier for the TRS-80 capture path.
// Cleans the raw hsync/vsync pins, measures hsync width, line period and
// lines per frame, classifies 64/80 column and 50/60Hz timing, and reports
// lock for the DPLL NCO select and the capture counter presets.
// line_strobe and frame_strobe are single-cycle event pulses with no
// backpressure: a consumer must take them in the cycle they are high.
module sync_mode_detect #(
  parameter int GLITCH_N   = 3,
  parameter int WIDTH_THR  = 142,
  parameter int PER_MIN    = 1500,
  parameter int PER_MAX    = 1700,
  parameter int LINES_THR  = 288,
  parameter int LOCK_LINES = 64,
  parameter int MISS_MAX   = 4
) (
  input  logic        vgaclk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        hsync_clean,
  output logic        vsync_clean,
  output logic        line_strobe,
  output logic        frame_strobe,
  output logic [7:0]  hsync_width,
  output logic [10:0] line_period,
  output logic [9:0]  frame_lines,
  output logic        mode80,
  output logic        hz50,
  output logic        locked,
  output logic [1:0]  dbg_state
);

  localparam int              GW          = $clog2(GLITCH_N + 1);
  localparam logic [GW-1:0]   GLITCH_LAST = GW'(GLITCH_N - 1);
  localparam logic [7:0]      W_THR       = 8'(WIDTH_THR);
  localparam logic [10:0]     P_MIN       = 11'(PER_MIN);
  localparam logic [10:0]     P_MAX       = 11'(PER_MAX);
  localparam logic [10:0]     P_SAT       = 11'h7FF;
  localparam logic [9:0]      L_THR       = 10'(LINES_THR);
  localparam logic [9:0]      FR_MIN      = 10'd150;
  localparam logic [9:0]      FR_MAX      = 10'd400;
  localparam logic [9:0]      L_SAT       = 10'h3FF;
  localparam logic [7:0]      LOCK_CNT    = 8'(LOCK_LINES);
  localparam logic [2:0]      MISS_LAST   = 3'(MISS_MAX - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          h_meta, h_sync, h_prev;
  logic          v_meta, v_sync, v_prev;
  logic [GW-1:0] h_run, v_run;
  logic          h_rise, h_fall, v_fall;

  logic [7:0]    width_cnt;
  logic [10:0]   per_cnt, per_next;
  logic          per_valid, period_ok, per_sat;
  logic          cls80, line_good;

  logic [9:0]    line_cnt, fl_next;
  logic          fl_legal, frame_seen;

  logic [7:0]    good_cnt;
  logic [2:0]    miss_cnt;

  // hsync: 2-FF synchronizer, then a run filter that flips the clean level
  // only after GLITCH_N consecutive samples disagree with it.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      h_meta      <= 1'b0;
      h_sync      <= 1'b0;
      h_run       <= '0;
      hsync_clean <= 1'b0;
      h_prev      <= 1'b0;
    end else begin
      h_meta <= hsync_in;
      h_sync <= h_meta;
      h_prev <= hsync_clean;
      if (h_sync == hsync_clean) begin
        h_run <= '0;
      end else if (h_run == GLITCH_LAST) begin
        hsync_clean <= h_sync;
        h_run       <= '0;
      end else begin
        h_run <= h_run + 1'b1;
      end
    end
  end

  // vsync: same synchronizer and run filter as hsync.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      v_meta      <= 1'b0;
      v_sync      <= 1'b0;
      v_run       <= '0;
      vsync_clean <= 1'b0;
      v_prev      <= 1'b0;
    end else begin
      v_meta <= vsync_in;
      v_sync <= v_meta;
      v_prev <= vsync_clean;
      if (v_sync == vsync_clean) begin
        v_run <= '0;
      end else if (v_run == GLITCH_LAST) begin
        vsync_clean <= v_sync;
        v_run       <= '0;
      end else begin
        v_run <= v_run + 1'b1;
      end
    end
  end

  assign h_rise = hsync_clean & ~h_prev;
  assign h_fall = ~hsync_clean & h_prev;
  assign v_fall = ~vsync_clean & v_prev;

  // Combinational per-line qualifiers. The line is judged on the hsync fall,
  // when both its period (captured at the rise) and its width are known.
  always_comb begin
    per_next  = (per_cnt == P_SAT) ? P_SAT : per_cnt + 11'd1;
    per_sat   = (per_cnt == P_SAT);
    cls80     = (width_cnt < W_THR);
    line_good = period_ok && (cls80 == mode80);
    fl_next   = line_cnt;
    if (h_rise && (line_cnt != L_SAT)) begin
      fl_next = line_cnt + 10'd1;
    end
    fl_legal  = (fl_next >= FR_MIN) && (fl_next <= FR_MAX);
  end

  // Width and period measurement. The first rise after reset only arms the
  // period counter, so that line can never be judged legal.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      width_cnt   <= 8'd0;
      hsync_width <= 8'd0;
      per_cnt     <= 11'd0;
      line_period <= 11'd0;
      per_valid   <= 1'b0;
      period_ok   <= 1'b0;
      line_strobe <= 1'b0;
    end else begin
      line_strobe <= h_rise;
      if (h_rise) begin
        width_cnt <= 8'd1;
      end else if (hsync_clean && (width_cnt != 8'hFF)) begin
        width_cnt <= width_cnt + 8'd1;
      end
      if (h_fall) begin
        hsync_width <= width_cnt;
      end
      if (h_rise) begin
        line_period <= per_next;
        per_cnt     <= 11'd0;
        per_valid   <= 1'b1;
        period_ok   <= per_valid && (per_next >= P_MIN) && (per_next <= P_MAX);
      end else if (!per_sat) begin
        per_cnt <= per_cnt + 11'd1;
      end
    end
  end

  // Frame line counting. A rise coincident with the vsync fall belongs to
  // the closing frame; the new frame then starts from zero.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      line_cnt     <= 10'd0;
      frame_lines  <= 10'd0;
      frame_strobe <= 1'b0;
      hz50         <= 1'b0;
    end else begin
      frame_strobe <= v_fall;
      if (v_fall) begin
        frame_lines <= fl_next;
        line_cnt    <= 10'd0;
        if (fl_legal) begin
          hz50 <= (fl_next > L_THR);
        end
      end else begin
        line_cnt <= fl_next;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. A class change while locked goes straight back to
  // SEARCH, where the mode is rewritten from the new class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (h_fall && period_ok) state_d = TRACK;
      end
      TRACK: begin
        if (h_fall && !line_good) begin
          state_d = SEARCH;
        end else if ((good_cnt >= LOCK_CNT) && frame_seen) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (per_sat) begin
          state_d = SEARCH;
        end else if (h_fall && (cls80 != mode80)) begin
          state_d = SEARCH;
        end else if (h_fall && !line_good && (miss_cnt == MISS_LAST)) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Good/miss line counters, mode register and legal-frame flag.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      good_cnt   <= 8'd0;
      miss_cnt   <= 3'd0;
      mode80     <= 1'b0;
      frame_seen <= 1'b0;
      locked     <= 1'b0;
    end else begin
      locked <= (state_q == LOCKED);
      if ((state_q == SEARCH) && h_fall) begin
        mode80 <= cls80;
      end
      if (state_q == SEARCH) begin
        frame_seen <= 1'b0;
      end else if (v_fall && fl_legal) begin
        frame_seen <= 1'b1;
      end
      if (state_d == SEARCH) begin
        good_cnt <= 8'd0;
        miss_cnt <= 3'd0;
      end else if (state_q == SEARCH) begin
        good_cnt <= 8'd1;
        miss_cnt <= 3'd0;
      end else if (state_q == TRACK) begin
        miss_cnt <= 3'd0;
        if (h_fall && (good_cnt != LOCK_CNT)) begin
          good_cnt <= good_cnt + 8'd1;
        end
      end else if (h_fall) begin
        miss_cnt <= line_good ? 3'd0 : miss_cnt + 3'd1;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_sync_mode_detect.sv
// tb_sync_mode_detect: directed bench for sync_mode_detect.
// Line timing is shortened (100-clock lines, widths 40/20 against a
// threshold of 30) so several full frames fit in a short run.
module tb_sync_mode_detect;

  localparam int LINE_P = 100;
  localparam int W64    = 40;
  localparam int W80    = 20;
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic        vgaclk = 1'b0;
  logic        reset;
  logic        hsync_in;
  logic        vsync_in;
  logic        hsync_clean;
  logic        vsync_clean;
  logic        line_strobe;
  logic        frame_strobe;
  logic [7:0]  hsync_width;
  logic [10:0] line_period;
  logic [9:0]  frame_lines;
  logic        mode80;
  logic        hz50;
  logic        locked;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int line_strobes = 0;
  int frame_strobes = 0;

  sync_mode_detect #(
    .WIDTH_THR (30),
    .PER_MIN   (90),
    .PER_MAX   (110)
  ) dut (
    .vgaclk       (vgaclk),
    .reset        (reset),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .hsync_clean  (hsync_clean),
    .vsync_clean  (vsync_clean),
    .line_strobe  (line_strobe),
    .frame_strobe (frame_strobe),
    .hsync_width  (hsync_width),
    .line_period  (line_period),
    .frame_lines  (frame_lines),
    .mode80       (mode80),
    .hz50         (hz50),
    .locked       (locked),
    .dbg_state    (dbg_state)
  );

  // Clock and reset-free strobe counters.
  always #20 vgaclk = ~vgaclk;

  always @(negedge vgaclk) begin
    if (line_strobe)  line_strobes++;
    if (frame_strobe) frame_strobes++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One line: hsync high for w clocks, optional vsync pulse falling in the
  // low part, optional 2-clock glitch in the low part.
  task automatic drive_line(input int w, input bit vpulse, input bit glitch);
    int goff;
    goff = w + int'($urandom_range(15, 40));
    for (int c = 0; c < LINE_P; c++) begin
      @(negedge vgaclk);
      hsync_in = (c < w) || (glitch && (c == goff || c == goff + 1));
      if (vpulse) vsync_in = (c >= w + 5) && (c < w + 25);
    end
  endtask

  initial begin
    int s0;
    int f0;
    int waited;

    reset    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (4) @(negedge vgaclk);

    // Reset state
    check("rst_hsync_clean", 32'(hsync_clean), 0);
    check("rst_line_period", 32'(line_period), 0);
    check("rst_frame_lines", 32'(frame_lines), 0);
    check("rst_locked",      32'(locked),      0);
    check("rst_state",       32'(dbg_state),   32'(ST_SEARCH));
    reset = 1'b0;

    // 64-col 60Hz: partial frame, then 264 lines closed by vsync
    drive_line(W64, 1'b1, 1'b0);
    check("t1_partial_frame", 32'(frame_lines), 1);
    check("t1_first_line_search", 32'(dbg_state), 32'(ST_SEARCH));
    drive_line(W64, 1'b0, 1'b0);
    check("t1_track", 32'(dbg_state), 32'(ST_TRACK));
    for (int i = 2; i < 100; i++) drive_line(W64, 1'b0, 1'b0);
    check("t1_no_lock_without_frame", 32'(locked), 0);
    check("t1_still_track", 32'(dbg_state), 32'(ST_TRACK));
    for (int i = 100; i < 264; i++) drive_line(W64, 1'b0, 1'b0);
    f0 = frame_strobes;
    drive_line(W64, 1'b1, 1'b0);
    check("t1_frame_lines", 32'(frame_lines), 264);
    check("t1_frame_strobe", 32'(frame_strobes - f0), 1);
    check("t1_hz50", 32'(hz50), 0);
    check("t1_mode80", 32'(mode80), 0);
    check("t1_hsync_width", 32'(hsync_width), 40);
    check("t1_line_period", 32'(line_period), 100);
    check("t1_locked", 32'(locked), 1);
    check("t1_state", 32'(dbg_state), 32'(ST_LOCKED));

    // Glitches in every line are filtered out
    s0 = line_strobes;
    for (int i = 0; i < 8; i++) drive_line(W64, 1'b0, 1'b1);
    check("t3_strobes", 32'(line_strobes - s0), 8);
    check("t3_line_period", 32'(line_period), 100);
    check("t3_hsync_width", 32'(hsync_width), 40);
    check("t3_locked", 32'(locked), 1);

    // Width switch to 80-col, then a 312-line frame
    drive_line(W80, 1'b0, 1'b0);
    check("t5_unlock", 32'(locked), 0);
    check("t5_unlock_state", 32'(dbg_state), 32'(ST_SEARCH));
    check("t5_mode_held", 32'(mode80), 0);
    drive_line(W80, 1'b0, 1'b0);
    check("t5_mode80", 32'(mode80), 1);
    check("t5_track", 32'(dbg_state), 32'(ST_TRACK));
    drive_line(W80, 1'b1, 1'b0);
    for (int i = 1; i <= 200; i++) drive_line(W80, 1'b0, 1'b0);
    check("t5_no_lock_yet", 32'(locked), 0);
    for (int i = 201; i < 312; i++) drive_line(W80, 1'b0, 1'b0);
    drive_line(W80, 1'b1, 1'b0);
    check("t2_frame_lines", 32'(frame_lines), 312);
    check("t2_hz50", 32'(hz50), 1);
    check("t2_hsync_width", 32'(hsync_width), 20);
    check("t2_mode80", 32'(mode80), 1);
    check("t5_relock", 32'(locked), 1);

    // hsync lost: period counter saturates and lock drops
    hsync_in = 1'b0;
    repeat (1850) @(negedge vgaclk);
    check("t4_locked_before_sat", 32'(locked), 1);
    waited = 0;
    while (locked !== 1'b0 && waited < 400) begin
      @(negedge vgaclk);
      waited++;
    end
    check("t4_unlock_on_sat", 32'(locked), 0);
    check("t4_state", 32'(dbg_state), 32'(ST_SEARCH));
    check("t4_period_held", 32'(line_period), 100);
    drive_line(W64, 1'b0, 1'b0);
    check("t4_period_saturated", 32'(line_period), 2047);
    check("t4_search_after_sat", 32'(dbg_state), 32'(ST_SEARCH));
    check("t4_mode_rewritten", 32'(mode80), 0);
    drive_line(W64, 1'b0, 1'b0);
    check("t4_retrack", 32'(dbg_state), 32'(ST_TRACK));

    // Reset mid-line: immediate clear, first line after release unmeasured
    repeat (30) @(negedge vgaclk);
    reset = 1'b1;
    #1;
    check("t6_line_period", 32'(line_period), 0);
    check("t6_frame_lines", 32'(frame_lines), 0);
    check("t6_hsync_width", 32'(hsync_width), 0);
    check("t6_hz50", 32'(hz50), 0);
    check("t6_state", 32'(dbg_state), 32'(ST_SEARCH));
    repeat (3) @(negedge vgaclk);
    reset = 1'b0;
    repeat (94) @(negedge vgaclk);
    drive_line(W64, 1'b0, 1'b0);
    check("t6_first_line_not_good", 32'(dbg_state), 32'(ST_SEARCH));
    drive_line(W64, 1'b0, 1'b0);
    check("t6_second_line_track", 32'(dbg_state), 32'(ST_TRACK));
    check("t6_line_period", 32'(line_period), 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
